// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - two-stage pipelined barrel shifter (LSR/ASR/LSL/ROR) with sticky bit
// Stage 1 applies the low SPLIT shift levels; stage 2 applies the rest plus saturation.
module shift_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6,
  parameter int SPLIT   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dout,
  output logic               sticky
);

  localparam int LOG2W = $clog2(WIDTH);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // One shift level by k; returns {bits_discarded_or, shifted_value}.
  function automatic logic [WIDTH:0] shift_level(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       m,
                                                 input logic             fill,
                                                 input int               k);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    logic             s;
    ones = '1;
    r    = v;
    s    = 1'b0;
    case (m)
      MODE_LSR: begin
        s = |(v & ~(ones << k));
        r = v >> k;
      end
      MODE_ASR: begin
        s = |(v & ~(ones << k));
        r = (v >> k) | ({WIDTH{fill}} & ~(ones >> k));
      end
      MODE_LSL: begin
        s = |(v & ~(ones >> k));
        r = v << k;
      end
      default: begin
        r = (v >> k) | (v << (WIDTH - k));
      end
    endcase
    return {s, r};
  endfunction

  logic                 v1_q;
  logic [WIDTH-1:0]     r1_q;
  logic                 s1_q;
  logic                 msb1_q;
  logic [1:0]           mode1_q;
  logic [SHAMT_W-1:SPLIT] hi1_q;
  logic                 big1_q;

  logic                 v2_q;
  logic [WIDTH-1:0]     dout_q;
  logic                 sticky_q;

  logic                 adv1;
  logic                 adv2;

  logic [WIDTH-1:0]     r1_d;
  logic                 s1_d;
  logic                 big1_d;
  logic [WIDTH:0]       lvl1;

  logic [WIDTH-1:0]     r2_d;
  logic                 s2_d;
  logic [WIDTH:0]       lvl2;
  logic                 sat2;

  assign adv2      = !v2_q || out_ready;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign dout      = dout_q;
  assign sticky    = sticky_q;

  assign big1_d = |shamt[SHAMT_W-1:LOG2W];

  always_comb begin
    r1_d = din;
    s1_d = 1'b0;
    lvl1 = '0;
    for (int l = 0; l < SPLIT; l++) begin
      if (shamt[l]) begin
        lvl1 = shift_level(r1_d, mode, din[WIDTH-1], 1 << l);
        r1_d = lvl1[WIDTH-1:0];
        s1_d = s1_d | lvl1[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      r1_q    <= '0;
      s1_q    <= 1'b0;
      msb1_q  <= 1'b0;
      mode1_q <= '0;
      hi1_q   <= '0;
      big1_q  <= 1'b0;
    end else if (adv1) begin
      v1_q    <= in_valid;
      r1_q    <= r1_d;
      s1_q    <= s1_d;
      msb1_q  <= din[WIDTH-1];
      mode1_q <= mode;
      hi1_q   <= shamt[SHAMT_W-1:SPLIT];
      big1_q  <= big1_d;
    end
  end

  // The partial result plus partial sticky still covers every din bit, so their OR equals OR(din).
  always_comb begin
    r2_d = r1_q;
    s2_d = s1_q;
    lvl2 = '0;
    sat2 = (mode1_q != MODE_ROR) && (big1_q || (|hi1_q[SHAMT_W-1:LOG2W]));
    for (int l = SPLIT; l < LOG2W; l++) begin
      if (hi1_q[l]) begin
        lvl2 = shift_level(r2_d, mode1_q, msb1_q, 1 << l);
        r2_d = lvl2[WIDTH-1:0];
        s2_d = s2_d | lvl2[WIDTH];
      end
    end
    if (sat2) begin
      r2_d = (mode1_q == MODE_ASR) ? {WIDTH{msb1_q}} : '0;
      s2_d = (|r1_q) | s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q     <= 1'b0;
      dout_q   <= '0;
      sticky_q <= 1'b0;
    end else if (adv2) begin
      v2_q     <= v1_q;
      dout_q   <= r2_d;
      sticky_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - self-checking bench for shift_pipe against an arithmetic reference model
module tb_shift_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [5:0]  shamt;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        sticky;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [32:0] exp_q[$];
  logic        held   = 1'b0;
  logic [31:0] held_d = '0;
  logic        held_s = 1'b0;
  logic [31:0] last_d = '0;
  logic        last_s = 1'b0;

  shift_pipe #(.WIDTH(32), .SHAMT_W(6), .SPLIT(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .shamt(shamt), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .sticky(sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {sticky, dout} from the shift rules using wide arithmetic.
  function automatic logic [32:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] m);
    logic [63:0] w;
    logic [63:0] lowmask;
    logic [31:0] r;
    logic        s;
    if (m == 2'b11) begin
      w = {d, d} >> (sh % 32);
      return {1'b0, w[31:0]};
    end
    if (sh >= 32) begin
      r = (m == 2'b01 && d[31]) ? 32'hFFFF_FFFF : 32'h0;
      return {|d, r};
    end
    lowmask = (64'd1 << sh) - 64'd1;
    case (m)
      2'b00: begin r = d >> sh; s = |({32'h0, d} & lowmask); end
      2'b01: begin r = $signed(d) >>> sh; s = |({32'h0, d} & lowmask); end
      default: begin w = {32'h0, d} << sh; r = w[31:0]; s = |w[63:32]; end
    endcase
    return {s, r};
  endfunction

  task automatic step(input logic iv, input logic [31:0] d, input logic [5:0] sh,
                      input logic [1:0] m, input logic ordy, output logic acc);
    logic [32:0] e;
    @(negedge clk);
    in_valid  = iv;
    din       = d;
    shamt     = sh;
    mode      = m;
    out_ready = ordy;
    #1;
    if (held) begin
      check("hold_valid", out_valid, 1);
      check("hold_dout", dout, held_d);
      check("hold_sticky", sticky, held_s);
    end
    acc = iv && in_ready;
    if (acc) exp_q.push_back(ref_shift(d, int'(sh), m));
    if (out_valid && out_ready) begin
      check("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dout", dout, e[31:0]);
        check("sticky", sticky, e[32]);
      end
      pops++;
      last_d = dout;
      last_s = sticky;
    end
    held   = out_valid && !out_ready;
    held_d = dout;
    held_s = sticky;
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      step(1'b0, '0, '0, '0, 1'b1, acc);
      n++;
    end
    check("drain_bound", n < 20, 1);
  endtask

  task automatic directed(input string tag, input logic [31:0] d, input int sh, input logic [1:0] m,
                          input logic [31:0] ed, input logic es);
    int p0;
    logic acc;
    p0 = pops;
    step(1'b1, d, 6'(sh), m, 1'b1, acc);
    check({tag, "_acc"}, acc, 1);
    drain();
    check({tag, "_count"}, pops - p0, 1);
    check({tag, "_dout"}, last_d, ed);
    check({tag, "_sticky"}, last_s, es);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int accs;
    int p0;
    int n;
    logic [31:0] d;

    rst = 1'b0; in_valid = 1'b0; din = '0; shamt = '0; mode = '0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_sticky", sticky, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Latency: accept at edge N, out_valid visible after edge N+2.
    step(1'b1, 32'h8000_0001, 6'd1, 2'b00, 1'b0, acc);
    check("lat_acc", acc, 1);
    step(1'b0, '0, '0, '0, 1'b0, acc);
    check("lat_n1_valid", out_valid, 0);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    check("lat_n2_valid", out_valid, 1);
    drain();
    check("lat_dout", last_d, 32'h4000_0000);
    check("lat_sticky", last_s, 1);

    directed("asr31", 32'h8000_0000, 31, 2'b01, 32'hFFFF_FFFF, 1'b0);
    directed("asr40", 32'h8000_0000, 40, 2'b01, 32'hFFFF_FFFF, 1'b1);
    directed("lsr40", 32'h8000_0000, 40, 2'b00, 32'h0, 1'b1);
    directed("lsl28", 32'h0000_00FF, 28, 2'b10, 32'hF000_0000, 1'b1);
    directed("ror8", 32'h1234_5678, 8, 2'b11, 32'h7812_3456, 1'b0);
    directed("ror40", 32'h1234_5678, 40, 2'b11, 32'h7812_3456, 1'b0);
    directed("lsl0", 32'hDEAD_BEEF, 0, 2'b10, 32'hDEAD_BEEF, 1'b0);
    directed("asr0", 32'h8765_4321, 0, 2'b01, 32'h8765_4321, 1'b0);

    // Backpressure: 4 operands offered while the consumer stalls.
    accs = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, $urandom, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 1'b0, acc);
      accs += int'(acc);
    end
    check("bp_accepts", accs, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      step(i < 2, $urandom, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 1'b1, acc);
      accs += int'(acc);
    end
    check("bp_total_accepts", accs, 4);
    check("bp_release_pops", pops - p0, 4);
    drain();

    // Asynchronous reset with two operands in flight.
    step(1'b1, 32'hAAAA_5555, 6'd3, 2'b00, 1'b0, acc);
    step(1'b1, 32'h5555_AAAA, 6'd9, 2'b10, 1'b0, acc);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_dout", dout, 0);
    check("midrst_sticky", sticky, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    held = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, '0, 1'b1, acc);
      check("midrst_no_stale", out_valid, 0);
    end

    // Randomised sweep across every mode and shift amount with random stalls.
    for (int m = 0; m < 4; m++) begin
      for (int sh = 0; sh < 64; sh++) begin
        d = (sh % 5 == 0) ? (32'h8000_0000 | $urandom) : $urandom;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
          step(1'b1, d, 6'(sh), 2'(m), 1'($urandom_range(0, 1)), acc);
          n++;
        end
        check("rand_accept", acc, 1);
        if ($urandom_range(0, 3) == 0) step(1'b0, '0, '0, '0, 1'($urandom_range(0, 1)), acc);
      end
    end
    drain();
    check("final_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
